// File: rtl/fifo_pkg.sv
// Definitions shared by the synchronous FIFO and its pop-side reader.
// Holds the default data width, the width of the read statistics counter and the wrapping pointer increment.
package fifo_pkg;

  localparam int BW_DEFAULT = 8;
  localparam int RD_CNT_W   = 16;

  // The depth does not have to be a power of two, so wrap explicitly instead of relying on overflow.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular buffer that sits behind the FIFO pop port. It has a write port, a registered read head and an occupancy count.
// A flush empties it on the next edge. This block has no pop or credit logic.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int bW       = BW_DEFAULT,
  parameter int bufDepth = 3,
  parameter int cntW     = $clog2(bufDepth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [bW-1:0]   wr_data,
  input  logic            rd_en,
  output logic [bW-1:0]   rd_data,
  output logic            rd_valid,
  output logic [cntW-1:0] buf_cnt
);

  localparam int PtrW = (bufDepth > 1) ? $clog2(bufDepth) : 1;

  logic [bW-1:0]   mem_q [bufDepth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [cntW-1:0] cnt_q, cnt_d;
  logic [bW-1:0]   head_q, head_d;
  logic            valid_q, valid_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;

    if (wr_en) wr_ptr_d = PtrW'(ptr_inc(32'(wr_ptr_q), bufDepth));
    if (rd_en) rd_ptr_d = PtrW'(ptr_inc(32'(rd_ptr_q), bufDepth));

    if (wr_en && !rd_en)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;

    // The head register is loaded with the next item that will be at the head. That is the incoming
    // word when the buffer will otherwise be empty, and the slot after the current head when the head is consumed.
    if (wr_en && (cnt_q == '0 || (rd_en && cnt_q == cntW'(1)))) head_d = wr_data;
    else if (rd_en && cnt_q > cntW'(1))                          head_d = mem_q[rd_ptr_d];

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end

    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. The count and the valid bit keep stale words from ever being visible.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      a_no_overflow : assert (!(wr_en && !rd_en && cnt_q == cntW'(bufDepth)));
    end
  end
`endif

  assign rd_data  = head_q;
  assign rd_valid = valid_q;
  assign buf_cnt  = cnt_q;

endmodule

// File: rtl/fifo_pop_reader.sv
// Pop-side reader for the synchronous FIFO. It issues pops against local buffer credit and hides the FIFO's one-cycle read latency.
// Define FIFO_RD_STATS_EN to add the rdCount delivered-item counter port.
module fifo_pop_reader
  import fifo_pkg::*;
#(
  parameter int bW       = BW_DEFAULT,
  parameter int bufDepth = 3,
  parameter int cntW     = $clog2(bufDepth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bW-1:0]       popData,
  input  logic                empty,
  output logic                pop,
  output logic [bW-1:0]       outData,
  output logic                outValid,
  input  logic                outReady,
  input  logic                flush
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [RD_CNT_W-1:0] rdCount
`endif
);

  logic            in_flight_q, in_flight_d;
  logic            drop_next_q, drop_next_d;
  logic [cntW-1:0] buf_cnt;
  logic            has_credit;
  logic            wr_en;
  logic            rd_en;

  // Credit counts both the buffered items and the item in flight. The read in this cycle is not counted, so pop never depends on outReady.
  always_comb begin
    has_credit  = (int'(buf_cnt) + int'(in_flight_q)) < bufDepth;
    pop         = !empty && !flush && !rst && has_credit;
    in_flight_d = pop;
    drop_next_d = flush && (in_flight_q || pop);
    wr_en       = in_flight_q && !drop_next_q;
    rd_en       = outValid && outReady;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= 1'b0;
      drop_next_q <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      drop_next_q <= drop_next_d;
    end
  end

  fifo_rd_buf #(
    .bW       (bW),
    .bufDepth (bufDepth),
    .cntW     (cntW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (popData),
    .rd_en    (rd_en),
    .rd_data  (outData),
    .rd_valid (outValid),
    .buf_cnt  (buf_cnt)
  );

`ifdef FIFO_RD_STATS_EN
  logic [RD_CNT_W-1:0] rd_count_q, rd_count_d;

  // The counter wraps naturally. Only rst clears it; flush leaves it unchanged.
  always_comb begin
    rd_count_d = rd_count_q;
    if (rd_en) rd_count_d = rd_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_count_q <= '0;
    else     rd_count_q <= rd_count_d;
  end

  assign rdCount = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Self-checking bench for fifo_pop_reader. It models the FIFO with a push/pop-indexed ring array.
// It checks delivery order against a queue of pushed items.
module tb_fifo_pop_reader;

  localparam int BW    = 8;
  localparam int DEPTH = 3;
  localparam int RING  = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] popData = '0;
  logic          empty;
  logic          pop;
  logic [BW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          flush;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   rdCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] fifo_mem [RING];
  int            push_cnt = 0;
  int            pop_cnt  = 0;
  logic          pop_when_empty = 1'b0;
  logic [BW-1:0] got [$];
  logic [BW-1:0] exp_q [$];

  always #5 clk = ~clk;

  // FIFO model: registered read data one cycle after an accepted pop.
  assign empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (pop === 1'b1) begin
      if (empty) pop_when_empty <= 1'b1;
      else begin
        popData <= fifo_mem[pop_cnt % RING];
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  fifo_pop_reader #(
    .bW       (BW),
    .bufDepth (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .popData  (popData),
    .empty    (empty),
    .pop      (pop),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady),
    .flush    (flush)
`ifdef FIFO_RD_STATS_EN
    ,
    .rdCount  (rdCount)
`endif
  );

  task automatic push(input logic [BW-1:0] v);
    fifo_mem[push_cnt % RING] = v;
    push_cnt++;
  endtask

  // Records each word accepted downstream. It samples at the negedge before the accepting posedge.
  task automatic collect(input int n, input int max_cyc);
    int c = 0;
    got.delete();
    while (got.size() < n && c < max_cyc) begin
      if (outValid === 1'b1 && outReady === 1'b1) got.push_back(outData);
      @(negedge clk);
      c++;
    end
  endtask

  task automatic drain_all(input string name);
    int k = 0;
    outReady = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while ((!empty || outValid !== 1'b0 || pop !== 1'b0) && k < 200);
    repeat (3) @(negedge clk);
    n_tests++;
    if (!empty || outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: empty=%b outValid=%b after %0d cycles, required empty=1 outValid=0", name, empty, outValid, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; outReady = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (pop !== 1'b0 || outValid !== 1'b0 || outData !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: pop=%b outValid=%b outData=%h, required 0 0 00", c, pop, outValid, outData);
      end
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (pop !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_pop: pop=%b, required 1", pop);
    end
    drain_all("reset");
  endtask

  task automatic test_streaming();
    logic exp_valid, exp_pop;
    outReady = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    n_tests++;
    if (pop !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_first_pop: pop=%b, required 1", pop);
    end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_valid = (k >= 2 && k <= 9);
      exp_pop   = (k < 8);
      n_tests++;
      if (outValid !== exp_valid || (exp_valid && outData !== 8'(k - 1))) begin
        n_fail++;
        $display("FAIL stream_data[%0d]: outValid=%b outData=%h, required %b %h", k, outValid, outData, exp_valid, 8'(k - 1));
      end
      n_tests++;
      if (pop !== exp_pop) begin
        n_fail++;
        $display("FAIL stream_pop[%0d]: pop=%b, required %b", k, pop, exp_pop);
      end
    end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    outReady = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (pop === 1'b1) pops++;
      if (k >= 2) begin
        n_tests++;
        if (outValid !== 1'b1 || outData !== 8'h01) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: outValid=%b outData=%h, required 1 01", k, outValid, outData);
        end
      end
    end
    n_tests++;
    if (pops != 3 || pop !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pop_count: pops=%0d pop=%b, required 3 pops then 0", pops, pop);
    end
    outReady = 1'b1;
    collect(8, 60);
    n_tests++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL bp_count: delivered %0d items, required 8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL bp_item[%0d]: got %h, required %h", i, got[i], 8'(i + 1));
      end
    end
    n_tests++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: outValid=%b outData=%h after last item, required outValid=0", outValid, outData);
    end
  endtask

  task automatic test_flush();
    int pops = 0;
    outReady = 1'b0;
    @(negedge clk);
    for (int v = 3; v <= 8; v++) push(8'(v));
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (pop === 1'b1) pops++;
    end
    n_tests++;
    if (pops != 3) begin
      n_fail++;
      $display("FAIL flush_setup_pops: pops=%0d, required 3", pops);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_tests++;
    if (pop !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pop_low: pop=%b, required 0", pop);
    end
    @(negedge clk);
    n_tests++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid_drop: outValid=%b, required 0", outValid);
    end
    flush = 1'b0;
    outReady = 1'b1;
    collect(3, 40);
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL flush_count: delivered %0d items, required 3", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== 8'(i + 6)) begin
        n_fail++;
        $display("FAIL flush_item[%0d]: got %h, required %h", i, got[i], 8'(i + 6));
      end
    end
    n_tests++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_tail: outValid=%b outData=%h, required outValid=0", outValid, outData);
    end
  endtask

  task automatic test_empty_boundary();
    int pops = 0, valids = 0;
    outReady = 1'b1;
    @(negedge clk);
    push(8'hA5);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (pop === 1'b1) pops++;
      if (outValid === 1'b1) begin
        valids++;
        n_tests++;
        if (outData !== 8'hA5) begin
          n_fail++;
          $display("FAIL empty_data: outData=%h, required a5", outData);
        end
      end
    end
    n_tests++;
    if (pops != 1 || valids != 1) begin
      n_fail++;
      $display("FAIL empty_pulses: pops=%0d valid_cycles=%0d, required 1 and 1", pops, valids);
    end
  endtask

  task automatic test_random();
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data  = '0;
    logic [BW-1:0] v, e;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_tests++;
        if (outValid !== 1'b1 || outData !== prev_data) begin
          n_fail++;
          $display("FAIL rand_stable[%0d]: outValid=%b outData=%h, required 1 %h", c, outValid, outData, prev_data);
        end
      end
      if ($urandom_range(0, 99) < 60 && (push_cnt - pop_cnt) < 16) begin
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
      end
      outReady = ($urandom_range(0, 99) < 65);
      if (outValid === 1'b1 && outReady) begin
        n_tests++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (outData !== e) begin
          n_fail++;
          $display("FAIL rand_item[%0d]: outData=%h, required %h", c, outData, e);
        end
      end
      prev_stall = (outValid === 1'b1) && !outReady;
      prev_data  = outData;
    end
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      outReady = 1'b1;
      if (outValid === 1'b1) begin
        n_tests++;
        e = exp_q.pop_front();
        if (outData !== e) begin
          n_fail++;
          $display("FAIL rand_drain_item: outData=%h, required %h", outData, e);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_lost: %0d items never delivered, required 0", exp_q.size());
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (outValid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_extra: outValid=%b outData=%h with nothing pending, required 0", outValid, outData);
      end
    end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (rdCount !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset0: rdCount=%0d, required 0", rdCount);
    end
    outReady = 1'b1;
    for (int i = 0; i < 65538; i++) begin
      push(8'(i));
      @(negedge clk);
    end
    drain_all("stats");
    n_tests++;
    if (rdCount !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_wrap: rdCount=%0d, required 2", rdCount);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rdCount !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_flush: rdCount=%0d, required 2", rdCount);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (rdCount !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_rst: rdCount=%0d, required 0", rdCount);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_empty_boundary();
    test_random();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    n_tests++;
    if (pop_when_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_on_empty: pop_when_empty=%b, required 0", pop_when_empty);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
